// File: rtl/sha256_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_stream_if
//  Description : Job handshake and shared-memory bus of the SHA-256 engine.
//  Revision    : 1.0
// ============================================================================
interface sha256_stream_if;
  logic        start;
  logic [15:0] msg_words;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        done;
  logic        busy;
  logic        err;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  start, msg_words, message_addr, output_addr, mem_read_data,
    output done, busy, err, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output start, msg_words, message_addr, output_addr, mem_read_data,
    input  done, busy, err, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface
`default_nettype wire

// File: rtl/sha256_stream.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_stream
//  Description : Block-at-a-time SHA-256 of a word-aligned message in shared
//                memory, with internal padding and digest write-back.
//  Revision    : 1.0
// ============================================================================
module sha256_stream #(
  parameter int MAX_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  sha256_stream_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_WRITE, S_FIN, S_ERR
  } state_t;

  localparam logic [15:0] c_max_len = 16'(MAX_WORDS);

  localparam logic [31:0] c_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] c_iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_maddr;
  logic [15:0] r_oaddr;
  logic [6:0]  r_cnt;
  logic [7:0]  r_blk;
  logic [31:0] r_h [8];
  logic [31:0] r_w [16];
  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_hh;

  logic [15:0] w_blk_base;
  logic [15:0] w_last_base;
  logic [15:0] w_last_g;
  logic        w_last_blk;
  logic [15:0] w_rd_g;
  logic [15:0] w_cap_g;
  logic        w_rd_en;
  logic [31:0] w_cap_word;
  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_wnew;

  // The final block starts at (len+2) rounded down to 16 words; its last
  // word carries the bit length.
  assign w_blk_base  = {4'b0, r_blk, 4'b0};
  assign w_last_base = (r_len + 16'd2) & 16'hFFF0;
  assign w_last_g    = w_last_base + 16'd15;
  assign w_last_blk  = (w_blk_base == w_last_base);
  assign w_rd_g      = w_blk_base + {9'b0, r_cnt};
  assign w_cap_g     = w_rd_g - 16'd1;
  assign w_rd_en     = (r_state == S_LOAD) && (r_cnt < 7'd16) && (w_rd_g < r_len);

  always_comb begin
    w_cap_word = 32'h0;
    if (w_cap_g < r_len)
      w_cap_word = bus.mem_read_data;
    else if (w_cap_g == r_len)
      w_cap_word = 32'h8000_0000;
    else if (w_cap_g == w_last_g)
      w_cap_word = {11'b0, r_len, 5'b0};
  end

  assign w_t1   = r_hh + bsig1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + c_k[r_cnt[5:0]] + r_w[0];
  assign w_t2   = bsig0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
  assign w_wnew = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next = (bus.msg_words > c_max_len) ? S_ERR : S_LOAD;
      end
      S_LOAD:    if (r_cnt == 7'd16) w_next = S_COMPUTE;
      S_COMPUTE: if (r_cnt == 7'd63) w_next = S_UPDATE;
      S_UPDATE:  w_next = w_last_blk ? S_WRITE : S_LOAD;
      S_WRITE:   if (r_cnt == 7'd7) w_next = S_FIN;
      S_FIN:     w_next = S_IDLE;
      S_ERR:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_blk   <= '0;
      r_len   <= '0;
      r_maddr <= '0;
      r_oaddr <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? 7'd0 : r_cnt + 7'd1;
      if (r_state == S_IDLE && bus.start) begin
        r_len   <= bus.msg_words;
        r_maddr <= bus.message_addr;
        r_oaddr <= bus.output_addr;
        r_blk   <= '0;
      end else if (r_state == S_UPDATE) begin
        r_blk <= r_blk + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          for (int i = 0; i < 8; i++) r_h[i] <= c_iv[i];
      end
      S_LOAD: begin
        r_a <= r_h[0]; r_b <= r_h[1]; r_c <= r_h[2]; r_d <= r_h[3];
        r_e <= r_h[4]; r_f <= r_h[5]; r_g <= r_h[6]; r_hh <= r_h[7];
        if (r_cnt != 7'd0) begin
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
          r_w[15] <= w_cap_word;
        end
      end
      S_COMPUTE: begin
        r_hh <= r_g;
        r_g  <= r_f;
        r_f  <= r_e;
        r_e  <= r_d + w_t1;
        r_d  <= r_c;
        r_c  <= r_b;
        r_b  <= r_a;
        r_a  <= w_t1 + w_t2;
        for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
        r_w[15] <= w_wnew;
      end
      S_UPDATE: begin
        r_h[0] <= r_h[0] + r_a;  r_h[1] <= r_h[1] + r_b;
        r_h[2] <= r_h[2] + r_c;  r_h[3] <= r_h[3] + r_d;
        r_h[4] <= r_h[4] + r_e;  r_h[5] <= r_h[5] + r_f;
        r_h[6] <= r_h[6] + r_g;  r_h[7] <= r_h[7] + r_hh;
      end
      default: ;
    endcase
  end

  assign bus.mem_clk = clk;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_FIN) || (r_state == S_ERR);
  assign bus.err     = (r_state == S_ERR);
  assign bus.mem_we  = (r_state == S_WRITE);

  always_comb begin
    bus.mem_addr       = 16'h0;
    bus.mem_write_data = 32'h0;
    if (w_rd_en)
      bus.mem_addr = r_maddr + w_rd_g;
    else if (r_state == S_WRITE) begin
      bus.mem_addr       = r_oaddr + {9'b0, r_cnt};
      bus.mem_write_data = r_h[r_cnt[2:0]];
    end
  end

endmodule
`default_nettype wire
